// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// LSU wins ties unless it has already won MAX_LSU_STREAK grants in a row against a waiting IFU.
module mem_port_arbiter #(
  parameter int XLEN           = 32,
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ifu_req_valid_i,
  output logic              ifu_req_ready_o,
  input  logic [XLEN-1:0]   ifu_addr_i,
  output logic              ifu_resp_valid_o,
  output logic [XLEN-1:0]   ifu_resp_data_o,
  input  logic              lsu_req_valid_i,
  output logic              lsu_req_ready_o,
  input  logic [XLEN-1:0]   lsu_addr_i,
  input  logic              lsu_wen_i,
  input  logic [XLEN-1:0]   lsu_wdata_i,
  input  logic [XLEN/8-1:0] lsu_wstrb_i,
  output logic              lsu_resp_valid_o,
  output logic [XLEN-1:0]   lsu_resp_data_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic              mem_wen_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  output logic [XLEN/8-1:0] mem_wstrb_o,
  input  logic              mem_resp_valid_i,
  input  logic [XLEN-1:0]   mem_resp_data_i,
  output logic              busy_o
);

  localparam int SW = XLEN / 8;
  localparam logic [3:0] MAX_S = 4'(MAX_LSU_STREAK);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t          state, state_nxt;
  logic            owner_lsu;
  logic [3:0]      lsu_streak;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic            wen_q;
  logic [SW-1:0]   wstrb_q;
  logic            ifu_grant, lsu_grant;

  always_comb begin
    ifu_grant        = 1'b0;
    lsu_grant        = 1'b0;
    state_nxt        = state;
    mem_req_valid_o  = 1'b0;
    mem_addr_o       = '0;
    mem_wen_o        = 1'b0;
    mem_wdata_o      = '0;
    mem_wstrb_o      = '0;
    ifu_resp_valid_o = 1'b0;
    ifu_resp_data_o  = '0;
    lsu_resp_valid_o = 1'b0;
    lsu_resp_data_o  = '0;
    busy_o           = (state != IDLE);
    case (state)
      IDLE: begin
        // IFU only steals a contested slot once the LSU streak is exhausted
        if (lsu_req_valid_i && !(ifu_req_valid_i && lsu_streak == MAX_S)) lsu_grant = 1'b1;
        else if (ifu_req_valid_i)                                          ifu_grant = 1'b1;
        if (ifu_grant || lsu_grant) state_nxt = REQ;
      end
      REQ: begin
        mem_req_valid_o = 1'b1;
        mem_addr_o      = addr_q;
        mem_wen_o       = wen_q;
        mem_wdata_o     = wdata_q;
        mem_wstrb_o     = wstrb_q;
        if (mem_req_ready_i) state_nxt = RESP;
      end
      RESP: begin
        if (mem_resp_valid_i) begin
          state_nxt = IDLE;
          if (owner_lsu) begin
            lsu_resp_valid_o = 1'b1;
            lsu_resp_data_o  = mem_resp_data_i;
          end else begin
            ifu_resp_valid_o = 1'b1;
            ifu_resp_data_o  = mem_resp_data_i;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ifu_req_ready_o = ifu_grant;
  assign lsu_req_ready_o = lsu_grant;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      owner_lsu  <= 1'b0;
      lsu_streak <= '0;
      addr_q     <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
    end else begin
      state <= state_nxt;
      if (lsu_grant) begin
        owner_lsu  <= 1'b1;
        addr_q     <= lsu_addr_i;
        wen_q      <= lsu_wen_i;
        wdata_q    <= lsu_wdata_i;
        wstrb_q    <= lsu_wstrb_i;
        lsu_streak <= !ifu_req_valid_i     ? 4'd0 :
                      (lsu_streak == MAX_S) ? MAX_S : lsu_streak + 4'd1;
      end else if (ifu_grant) begin
        owner_lsu  <= 1'b0;
        addr_q     <= ifu_addr_i;
        wen_q      <= 1'b0;
        wdata_q    <= '0;
        wstrb_q    <= '0;
        lsu_streak <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: grant table, directed corner sequences and a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;
  localparam int MAXS = 4;

  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        ifu_req_valid_i = 0, ifu_req_ready_o, ifu_resp_valid_o;
  logic [31:0] ifu_addr_i = 0, ifu_resp_data_o;
  logic        lsu_req_valid_i = 0, lsu_req_ready_o, lsu_wen_i = 0, lsu_resp_valid_o;
  logic [31:0] lsu_addr_i = 0, lsu_wdata_i = 0, lsu_resp_data_o;
  logic [3:0]  lsu_wstrb_i = 0, mem_wstrb_o;
  logic        mem_req_valid_o, mem_req_ready_i = 0, mem_wen_o, mem_resp_valid_i = 0, busy_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_resp_data_i = 0;

  mem_port_arbiter #(.XLEN(32), .MAX_LSU_STREAK(MAXS)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ifu_req_valid_i(ifu_req_valid_i), .ifu_req_ready_o(ifu_req_ready_o), .ifu_addr_i(ifu_addr_i),
    .ifu_resp_valid_o(ifu_resp_valid_o), .ifu_resp_data_o(ifu_resp_data_o),
    .lsu_req_valid_i(lsu_req_valid_i), .lsu_req_ready_o(lsu_req_ready_o), .lsu_addr_i(lsu_addr_i),
    .lsu_wen_i(lsu_wen_i), .lsu_wdata_i(lsu_wdata_i), .lsu_wstrb_i(lsu_wstrb_i),
    .lsu_resp_valid_o(lsu_resp_valid_o), .lsu_resp_data_o(lsu_resp_data_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_addr_o(mem_addr_o),
    .mem_wen_o(mem_wen_o), .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_data_i(mem_resp_data_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0, n_pass = 0;
  int streak_m = 0;
  int ifu_pulses = 0, lsu_pulses = 0;

  always @(negedge clk_i) begin
    if (ifu_resp_valid_o) ifu_pulses++;
    if (lsu_resp_valid_o) lsu_pulses++;
  end

  typedef struct { logic iv; logic lv; logic exp_ir; logic exp_lr; } gvec_t;
  gvec_t tbl[4];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic chk_quiet(input string name);
    chk(name, {ifu_req_ready_o, ifu_resp_valid_o, ifu_resp_data_o, lsu_req_ready_o, lsu_resp_valid_o,
               lsu_resp_data_o, mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wstrb_o, busy_o}, 0);
  endtask

  task automatic reset_dut();
    rst_i = 1; ifu_req_valid_i = 0; lsu_req_valid_i = 0;
    mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_resp_data_i = 0;
    repeat (2) tick();
    rst_i = 0; streak_m = 0;
  endtask

  // Expected grant from the requester valids and the modelled LSU streak; advances to the accept edge
  task automatic arb(output logic own, output logic [31:0] a, output logic w,
                     output logic [31:0] d, output logic [3:0] s);
    logic el, ei;
    @(negedge clk_i);
    el = lsu_req_valid_i && !(ifu_req_valid_i && streak_m == MAXS);
    ei = ifu_req_valid_i && !el;
    chk("ifu_ready", ifu_req_ready_o, ei);
    chk("lsu_ready", lsu_req_ready_o, el);
    chk("busy_idle", busy_o, 0);
    own = el;
    if (el) begin
      a = lsu_addr_i; w = lsu_wen_i; d = lsu_wdata_i; s = lsu_wstrb_i;
      streak_m = !ifu_req_valid_i ? 0 : (streak_m + 1 > MAXS ? MAXS : streak_m + 1);
    end else begin
      a = ifu_addr_i; w = 0; d = 0; s = 0; streak_m = 0;
    end
    tick();
  endtask

  // Memory side of one transaction, entered in the first REQ cycle
  task automatic serve(input logic own, input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, input int rdly, input int pdly, input logic [31:0] rd);
    mem_req_ready_i = 0;
    for (int i = 0; i < rdly; i++) begin
      mem_resp_valid_i = 1'($urandom_range(0, 1)); mem_resp_data_i = $urandom;
      @(negedge clk_i);
      chk("req_valid", mem_req_valid_o, 1);
      chk("req_fields", {mem_addr_o, mem_wen_o, mem_wdata_o, mem_wstrb_o}, {a, w, d, s});
      chk("no_resp_in_req", {ifu_resp_valid_o, lsu_resp_valid_o, ifu_resp_data_o, lsu_resp_data_o}, 0);
      chk("busy_req", busy_o, 1);
      tick();
    end
    mem_resp_valid_i = 0; mem_resp_data_i = 0; mem_req_ready_i = 1;
    @(negedge clk_i);
    chk("req_valid", mem_req_valid_o, 1);
    chk("req_fields", {mem_addr_o, mem_wen_o, mem_wdata_o, mem_wstrb_o}, {a, w, d, s});
    tick();
    mem_req_ready_i = 0;
    for (int i = 0; i < pdly; i++) begin
      @(negedge clk_i);
      chk("resp_wait", {mem_req_valid_o, ifu_resp_valid_o, lsu_resp_valid_o, busy_o}, 4'b0001);
      tick();
    end
    mem_resp_valid_i = 1; mem_resp_data_i = rd;
    @(negedge clk_i);
    chk("resp_route", {ifu_resp_valid_o, lsu_resp_valid_o}, {!own, own});
    if (own) begin
      chk("ifu_data_idle", ifu_resp_data_o, 0);
      if (!w) chk("lsu_data", lsu_resp_data_o, rd);
    end else begin
      chk("ifu_data", ifu_resp_data_o, rd);
      chk("lsu_data_idle", lsu_resp_data_o, 0);
    end
    tick();
    mem_resp_valid_i = 0; mem_resp_data_i = 0;
  endtask

  logic        own, w;
  logic [31:0] a, d;
  logic [3:0]  s;
  logic [9:0]  order;

  initial begin
    tbl[0] = '{0, 0, 0, 0};
    tbl[1] = '{1, 0, 1, 0};
    tbl[2] = '{0, 1, 0, 1};
    tbl[3] = '{1, 1, 0, 1};

    reset_dut();
    @(negedge clk_i);
    chk_quiet("reset_state");
    tick();

    for (int i = 0; i < 4; i++) begin
      reset_dut();
      ifu_req_valid_i = tbl[i].iv; lsu_req_valid_i = tbl[i].lv;
      @(negedge clk_i);
      chk($sformatf("tbl%0d_ready", i), {ifu_req_ready_o, lsu_req_ready_o}, {tbl[i].exp_ir, tbl[i].exp_lr});
      chk($sformatf("tbl%0d_quiet", i), {mem_req_valid_o, busy_o}, 0);
      tick();
    end

    // IFU only, zero-latency memory
    reset_dut();
    ifu_pulses = 0; lsu_pulses = 0;
    ifu_req_valid_i = 1; ifu_addr_i = 32'h8000_0000;
    arb(own, a, w, d, s);
    ifu_req_valid_i = 0;
    chk("ifu_only_owner", own, 0);
    serve(own, 32'h8000_0000, 0, 0, 0, 0, 0, 32'h0010_0093);
    @(negedge clk_i);
    chk("ifu_only_pulses", {ifu_pulses[7:0], lsu_pulses[7:0]}, 16'h0100);
    chk_quiet("ifu_only_done");

    // LSU store held off by memory for three REQ cycles
    reset_dut();
    ifu_pulses = 0; lsu_pulses = 0;
    lsu_req_valid_i = 1; lsu_wen_i = 1; lsu_addr_i = 32'h8000_1000;
    lsu_wdata_i = 32'hDEAD_BEEF; lsu_wstrb_i = 4'hF;
    arb(own, a, w, d, s);
    lsu_req_valid_i = 0;
    serve(1, 32'h8000_1000, 1, 32'hDEAD_BEEF, 4'hF, 3, 1, 32'h5555_AAAA);
    @(negedge clk_i);
    chk("store_pulses", {ifu_pulses[7:0], lsu_pulses[7:0]}, 16'h0001);

    // Both requesting continuously: four LSU grants then one IFU grant
    reset_dut();
    order = 10'b1111011110;
    ifu_req_valid_i = 1; ifu_addr_i = 32'h0000_0100;
    lsu_req_valid_i = 1; lsu_wen_i = 0; lsu_addr_i = 32'h0000_0200; lsu_wdata_i = 0; lsu_wstrb_i = 0;
    for (int i = 0; i < 10; i++) begin
      arb(own, a, w, d, s);
      chk($sformatf("streak_grant%0d", i), own, order[9-i]);
      serve(own, a, w, d, s, 0, 0, $urandom);
    end

    // Payload changes after accept must not reach memory
    reset_dut();
    ifu_req_valid_i = 0;
    lsu_req_valid_i = 1; lsu_wen_i = 0; lsu_addr_i = 32'h0000_3000; lsu_wdata_i = 0; lsu_wstrb_i = 0;
    arb(own, a, w, d, s);
    lsu_req_valid_i = 0; lsu_addr_i = 32'h0000_4444; lsu_wen_i = 1; lsu_wdata_i = 32'hFFFF_FFFF;
    serve(1, 32'h0000_3000, 0, 0, 0, 2, 0, 32'h0BAD_F00D);

    // Reset while waiting for a response, then a stale response arrives
    reset_dut();
    ifu_pulses = 0; lsu_pulses = 0;
    ifu_req_valid_i = 1; ifu_addr_i = 32'h8000_0040;
    arb(own, a, w, d, s);
    ifu_req_valid_i = 0; mem_req_ready_i = 1;
    tick();
    mem_req_ready_i = 0;
    @(negedge clk_i);
    chk("resp_state_busy", {busy_o, mem_req_valid_o}, 2'b10);
    rst_i = 1;
    tick();
    rst_i = 0;
    @(negedge clk_i);
    chk_quiet("after_reset_resp");
    tick();
    mem_resp_valid_i = 1; mem_resp_data_i = 32'hCAFE_0001;
    @(negedge clk_i);
    chk_quiet("stale_resp_ignored");
    tick();
    mem_resp_valid_i = 0; mem_resp_data_i = 0;
    @(negedge clk_i);
    chk("reset_resp_pulses", {ifu_pulses[7:0], lsu_pulses[7:0]}, 0);
    tick();

    // Spurious response in IDLE
    reset_dut();
    mem_resp_valid_i = 1; mem_resp_data_i = 32'h1234_5678;
    @(negedge clk_i);
    chk_quiet("spurious0");
    tick();
    @(negedge clk_i);
    chk_quiet("spurious1");
    tick();
    mem_resp_valid_i = 0; mem_resp_data_i = 0;

    // Randomized traffic; losers hold valid and payload until granted
    reset_dut();
    for (int t = 0; t < 80; t++) begin
      if (!ifu_req_valid_i && $urandom_range(0, 1) == 1) begin
        ifu_req_valid_i = 1; ifu_addr_i = $urandom;
      end
      if (!lsu_req_valid_i && $urandom_range(0, 2) != 0) begin
        lsu_req_valid_i = 1; lsu_addr_i = $urandom; lsu_wen_i = 1'($urandom_range(0, 1));
        lsu_wdata_i = $urandom; lsu_wstrb_i = 4'($urandom_range(0, 15));
      end
      if (!ifu_req_valid_i && !lsu_req_valid_i) begin
        ifu_req_valid_i = 1; ifu_addr_i = $urandom;
      end
      arb(own, a, w, d, s);
      if (own) lsu_req_valid_i = 0; else ifu_req_valid_i = 0;
      serve(own, a, w, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
